// File: rtl/restoring_div.sv
// rtl/restoring_div.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
//
// Purpose: unsigned N-bit division with quotient and remainder. Each step
//   shifts {R,Q} left, trial-subtracts the divisor through a carry-lookahead
//   adder (R + ~D + 1), and keeps the difference only when no borrow occurs.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   start                 - launch request, accepted in IDLE or DONE
//   dividend, divisor     - N-bit operands, captured on acceptance
//   busy                  - division in progress
//   done                  - one-cycle result-valid pulse
//   quotient, remainder   - results, held until the next done
//   div_by_zero           - captured divisor was zero (detect build only)
// Optional feature macro: RESTORING_DIV_ZERO_DETECT_EN
//   defined   - zero divisor skips RUN, results in one cycle, div_by_zero=1
//   undefined - zero divisor runs all N steps, div_by_zero tied to 0
module restoring_div #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int W  = N + 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  // The accumulator is N+1 bits only after the shift; between steps it is
  // always below the divisor, so N bits of storage suffice.
  logic [N-1:0]  r;
  logic [N-1:0]  q;
  logic [N-1:0]  d;
  logic [CW-1:0] cnt;

  logic [W-1:0]  r_sh;
  logic [W-1:0]  sub_b;
  logic [W-1:0]  g;
  logic [W-1:0]  p;
  logic [W:0]    c;
  logic          grp_g;
  logic          grp_p;
  logic [N-1:0]  trial;
  logic          no_borrow;
  logic          accept;

`ifdef RESTORING_DIV_ZERO_DETECT_EN
  logic          zflag;
`else
  assign div_by_zero = 1'b0;
`endif

  assign r_sh  = {r, q[N-1]};
  assign sub_b = ~{1'b0, d};
  assign g     = r_sh & sub_b;
  assign p     = r_sh ^ sub_b;

  // Carry lookahead: each carry is the group generate/propagate of all lower
  // bits, with the carry-in fixed at 1 to complete the two's complement.
  always_comb begin
    c     = '0;
    c[0]  = 1'b1;
    grp_g = 1'b0;
    grp_p = 1'b1;
    for (int i = 0; i < W; i++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int j = 0; j <= i; j++) begin
        grp_g = g[j] | (p[j] & grp_g);
        grp_p = grp_p & p[j];
      end
      c[i+1] = grp_g | grp_p;
    end
  end

  // Top bit of the difference is always 0 whenever it is kept.
  assign trial     = p[N-1:0] ^ c[N-1:0];
  assign no_borrow = c[W];
  assign accept    = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      r         <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef RESTORING_DIV_ZERO_DETECT_EN
      zflag       <= 1'b0;
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: state <= IDLE;
        RUN: begin
          r   <= no_borrow ? trial : r_sh[N-1:0];
          q   <= {q[N-2:0], no_borrow};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
`ifdef RESTORING_DIV_ZERO_DETECT_EN
          if (zflag) begin
            quotient    <= '1;
            remainder   <= q;       // Q still holds the captured dividend
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q;
            remainder   <= r;
            div_by_zero <= 1'b0;
          end
`else
          quotient  <= q;
          remainder <= r;
`endif
        end
        default: state <= IDLE;
      endcase

      // Acceptance in DONE overrides the return to IDLE for back-to-back use.
      if (accept) begin
        r     <= '0;
        q     <= dividend;
        d     <= divisor;
        cnt   <= '0;
        busy  <= 1'b1;
        state <= RUN;
`ifdef RESTORING_DIV_ZERO_DETECT_EN
        zflag <= (divisor == '0);
        if (divisor == '0) begin
          busy  <= 1'b0;
          state <= DONE;
        end
`endif
      end
    end
  end

endmodule
